// File: rtl/prince_sbox_cms_pipe.sv
// prince_sbox_cms_pipe
// First-order CMS-masked PRINCE S-box layer with NIBBLES parallel S-boxes and
// a two-stage pipeline.
// Stage 1 registers the 16 non-complete components of every output bit.
// Each component is refreshed with fresh randomness before it is registered.
// Stage 2 compresses the components into two output shares.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     input handshake (in_ready is combinational)
//   in_sh0, in_sh1          input shares, nibble n = [4n+3:4n] (bit3 x .. bit0 w)
//   rand_i                  fresh randomness, [32n+8b+7:32n+8b] = r[0..7] of nibble n, bit b
//   out_valid / out_ready   output handshake
//   out_sh0, out_sh1        registered output shares
module prince_sbox_cms_pipe #(
    parameter int unsigned NIBBLES      = 16,
    parameter int unsigned RAND_PER_BIT = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [4*NIBBLES-1:0]               in_sh0,
    input  logic [4*NIBBLES-1:0]               in_sh1,
    input  logic [4*RAND_PER_BIT*NIBBLES-1:0]  rand_i,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [4*NIBBLES-1:0]               out_sh0,
    output logic [4*NIBBLES-1:0]               out_sh1
);

    localparam int unsigned NCOMP  = 16;
    localparam int unsigned HALF   = NCOMP / 2;
    localparam int unsigned DW     = 4 * NIBBLES;
    localparam int unsigned RW     = 4 * RAND_PER_BIT;
    localparam int unsigned COMP_W = DW * NCOMP;

    // PRINCE S-box truth table, entry i at [4i+3:4i].
    localparam logic [63:0] SBOX = 64'h4D5E_0876_19CA_23FB;

    // Algebraic normal form of each output bit: ANF[16b+u] is the coefficient
    // of the monomial whose variable set is the mask u (Moebius transform).
    function automatic logic [63:0] sbox_anf();
        logic [63:0] a;
        a = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            for (int unsigned u = 0; u < 16; u++) begin
                for (int unsigned v = 0; v < 16; v++) begin
                    if ((4'(v) & ~4'(u)) == 4'b0) begin
                        a[6'(b*16 + u)] = a[6'(b*16 + u)] ^ SBOX[6'(v*4 + b)];
                    end
                end
            end
        end
        return a;
    endfunction

    localparam logic [63:0] ANF = sbox_anf();

    // Component k of output bit b: every ANF monomial whose variable set covers
    // the variables k picks from share 1. Each variable of the monomial is read
    // from the share that k selects for it, so only one share per variable is
    // ever read.
    function automatic logic comp_bit(input int unsigned b, input logic [3:0] k,
                                      input logic [3:0] a0, input logic [3:0] a1);
        logic       acc;
        logic       prod;
        logic [3:0] u;
        acc = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            u = 4'(i);
            if (((k & ~u) == 4'b0) && ANF[6'(b*16 + i)]) begin
                prod = 1'b1;
                for (int unsigned v = 0; v < 4; v++) begin
                    if (u[2'(v)]) begin
                        prod = prod & (k[2'(v)] ? a1[2'(v)] : a0[2'(v)]);
                    end
                end
                acc = acc ^ prod;
            end
        end
        return acc;
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic [COMP_W-1:0] comp_c;
    logic [COMP_W-1:0] comp_q, comp_d;
    logic [DW-1:0]     sh0_c, sh1_c;
    logic [DW-1:0]     out_sh0_q, out_sh0_d;
    logic [DW-1:0]     out_sh1_q, out_sh1_d;
    logic              s1_adv;
    logic              in_fire;

    // Component functions plus refresh.
    // r[j] enters c[j] and c[j+8], so it cancels when the two halves are combined.
    for (genvar n = 0; n < NIBBLES; n++) begin : g_nib
        for (genvar b = 0; b < 4; b++) begin : g_bit
            for (genvar k = 0; k < NCOMP; k++) begin : g_comp
                localparam int unsigned J = k % HALF;
                assign comp_c[(n*4 + b)*NCOMP + k] =
                    comp_bit(b, 4'(k), in_sh0[4*n +: 4], in_sh1[4*n +: 4])
                    ^ rand_i[n*RW + b*RAND_PER_BIT + J];
            end
            // Compression: components 0..7 form share 0 and components 8..15 form share 1.
            assign sh0_c[4*n + b] = ^comp_q[(n*4 + b)*NCOMP +: HALF];
            assign sh1_c[4*n + b] = ^comp_q[(n*4 + b)*NCOMP + HALF +: HALF];
        end
    end

    // Handshake and next-state logic.
    always_comb begin
        s1_adv     = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready   = !s1_valid_q || s1_adv;
        in_fire    = in_valid && in_ready;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        comp_d     = comp_q;
        out_sh0_d  = out_sh0_q;
        out_sh1_d  = out_sh1_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            comp_d     = comp_c;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            out_sh0_d  = sh0_c;
            out_sh1_d  = sh1_c;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            comp_q     <= '0;
            out_sh0_q  <= '0;
            out_sh1_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            comp_q     <= comp_d;
            out_sh0_q  <= out_sh0_d;
            out_sh1_q  <= out_sh1_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sh0   = out_sh0_q;
    assign out_sh1   = out_sh1_q;

endmodule

// File: tb/tb_prince_sbox_cms_pipe.sv
// Directed testbench for prince_sbox_cms_pipe (NIBBLES = 16).
module tb_prince_sbox_cms_pipe;

    localparam int unsigned NIB = 16;
    localparam int unsigned DW  = 4 * NIB;
    localparam int unsigned RW  = 32 * NIB;
    localparam int unsigned CW  = DW * 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_sh0;
    logic [DW-1:0] in_sh1;
    logic [RW-1:0] rand_i;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sh0;
    logic [DW-1:0] out_sh1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] sb [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                            4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

    prince_sbox_cms_pipe #(.NIBBLES(NIB), .RAND_PER_BIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sh0    (in_sh0),
        .in_sh1    (in_sh1),
        .rand_i    (rand_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sh0   (out_sh0),
        .out_sh1   (out_sh1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] sbox_vec(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        r = '0;
        for (int n = 0; n < NIB; n++) r[4*n +: 4] = sb[x[4*n +: 4]];
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_vec();
        logic [RW-1:0] r;
        for (int i = 0; i < RW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_dw();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive inputs, sample the handshake before the edge, advance.
    task automatic drive(input logic v, input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                         input logic [RW-1:0] r, input logic ordy,
                         output logic acc, output logic ov,
                         output logic [DW-1:0] o0, output logic [DW-1:0] o1);
        in_valid  = v;
        in_sh0    = s0;
        in_sh1    = s1;
        rand_i    = r;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        ov  = out_valid;
        o0  = out_sh0;
        o1  = out_sh1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sh0 = '0; in_sh1 = '0; rand_i = '0; out_ready = 1'b1;
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_sh0 !== '0) begin n_fail++; $display("FAIL reset_out_sh0: got %h expected 0", out_sh0); end
        n_checks++; if (out_sh1 !== '0) begin n_fail++; $display("FAIL reset_out_sh1: got %h expected 0", out_sh1); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic acc, ov;
        logic [DW-1:0] o0, o1;
        drive(1'b1, {NIB{4'h5}}, {NIB{4'h5}}, '0, 1'b1, acc, ov, o0, o1);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b expected 1", acc); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: got out_valid %b expected 0", out_valid); end
        drive(1'b0, '0, '0, '0, 1'b1, acc, ov, o0, o1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency2: got out_valid %b expected 1", out_valid); end
        n_checks++; if ((out_sh0 ^ out_sh1) !== 64'hBBBB_BBBB_BBBB_BBBB) begin
            n_fail++; $display("FAIL basic_xor: got %h expected BBBBBBBBBBBBBBBB", out_sh0 ^ out_sh1); end
        drive(1'b0, '0, '0, '0, 1'b1, acc, ov, o0, o1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got out_valid %b expected 0", out_valid); end
    endtask

    // All 256 share pairs, 16 per transaction, streamed with out_ready held high.
    task automatic test_exhaustive_stream();
        logic acc, ov;
        logic [DW-1:0] o0, o1, s0, s1, e;
        logic [DW-1:0] exp_q [$];
        int sent, recv, c;
        sent = 0; recv = 0; c = 0;
        while ((sent < 16 || recv < 16) && c < 60) begin
            for (int n = 0; n < NIB; n++) begin
                s0[4*n +: 4] = 4'(sent);
                s1[4*n +: 4] = 4'(n);
            end
            drive(sent < 16, s0, s1, rand_vec(), 1'b1, acc, ov, o0, o1);
            if (c < 16) begin
                n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cyc %0d: got %b expected 1", c, acc); end
            end
            if (acc) begin exp_q.push_back(sbox_vec(s0 ^ s1)); sent++; end
            if (ov) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL stream_extra cyc %0d: unexpected output %h expected none", c, o0 ^ o1);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if ((o0 ^ o1) !== e) begin n_fail++; $display("FAIL stream_xor #%0d: got %h expected %h", recv, o0 ^ o1, e); end
                    recv++;
                end
            end
            if (c >= 1 && c <= 16) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_out_valid cyc %0d: got %b expected 1", c, out_valid); end
            end
            c++;
        end
        n_checks++; if (recv != 16) begin n_fail++; $display("FAIL stream_count: got %0d expected 16", recv); end
    endtask

    // Fixed unmasked value x=7 under varying masks and randomness.
    task automatic test_rand_variation();
        logic acc, ov;
        logic [DW-1:0] o0, o1, s0, prev;
        int sent, recv, changes, c;
        sent = 0; recv = 0; changes = 0; c = 0; prev = '0;
        while ((sent < 100 || recv < 100) && c < 200) begin
            s0 = rand_dw();
            drive(sent < 100, s0, s0 ^ {NIB{4'h7}}, rand_vec(), 1'b1, acc, ov, o0, o1);
            if (acc) sent++;
            if (ov) begin
                n_checks++; if ((o0 ^ o1) !== {NIB{4'h1}}) begin n_fail++; $display("FAIL randvar_xor #%0d: got %h expected 1111111111111111", recv, o0 ^ o1); end
                if (recv > 0 && o0 != prev) changes++;
                prev = o0;
                recv++;
            end
            c++;
        end
        n_checks++; if (recv != 100) begin n_fail++; $display("FAIL randvar_count: got %0d expected 100", recv); end
        n_checks++; if (changes < 90) begin n_fail++; $display("FAIL randvar_share_varies: got %0d changes expected >= 90", changes); end
    endtask

    task automatic test_backpressure();
        logic acc, ov, ordy, prev_stall;
        logic [DW-1:0] o0, o1, s0, s1, e, p0, p1;
        logic [DW-1:0] exp_q [$];
        int sent, recv, c;
        sent = 0; recv = 0; c = 0; prev_stall = 1'b0; p0 = '0; p1 = '0;
        while (recv < 5 && c < 40) begin
            ordy = !(c >= 3 && c <= 6);
            s0 = rand_dw(); s1 = rand_dw();
            drive(sent < 5, s0, s1, rand_vec(), ordy, acc, ov, o0, o1);
            if (c <= 2) begin
                n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready cyc %0d: got %b expected 1", c, acc); end
            end else if (c <= 6) begin
                n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL bp_full cyc %0d: got in_ready %b expected 0", c, acc); end
            end
            if (prev_stall) begin
                n_checks++; if (ov !== 1'b1 || o0 !== p0 || o1 !== p1) begin
                    n_fail++; $display("FAIL bp_stable cyc %0d: got %b %h %h expected 1 %h %h", c, ov, o0, o1, p0, p1); end
            end
            if (acc) begin exp_q.push_back(sbox_vec(s0 ^ s1)); sent++; end
            if (ov && ordy) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL bp_extra cyc %0d: unexpected output %h expected none", c, o0 ^ o1);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if ((o0 ^ o1) !== e) begin n_fail++; $display("FAIL bp_order #%0d: got %h expected %h", recv, o0 ^ o1, e); end
                    recv++;
                end
            end
            prev_stall = ov && !ordy;
            p0 = o0; p1 = o1;
            c++;
        end
        n_checks++; if (recv != 5) begin n_fail++; $display("FAIL bp_count: got %0d expected 5", recv); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, '0, 1'b1, acc, ov, o0, o1);
            n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL bp_duplicate idle %0d: got out_valid %b expected 0", i, ov); end
        end
    endtask

    task automatic test_reset_midstream();
        logic acc, ov;
        logic [DW-1:0] o0, o1;
        drive(1'b1, rand_dw(), rand_dw(), rand_vec(), 1'b0, acc, ov, o0, o1);
        drive(1'b1, rand_dw(), rand_dw(), rand_vec(), 1'b0, acc, ov, o0, o1);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_full: got out_valid %b in_ready %b expected 1 0", out_valid, in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_sh0 !== '0 || out_sh1 !== '0) begin n_fail++; $display("FAIL rstmid_shares: got %h %h expected 0 0", out_sh0, out_sh1); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        drive(1'b1, {NIB{4'hA}}, {NIB{4'h5}}, rand_vec(), 1'b1, acc, ov, o0, o1);
        n_checks++; if (acc !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_first: got accept %b out_valid %b expected 1 0", acc, out_valid); end
        drive(1'b0, '0, '0, '0, 1'b1, acc, ov, o0, o1);
        n_checks++; if (out_valid !== 1'b1 || (out_sh0 ^ out_sh1) !== {NIB{4'h4}}) begin
            n_fail++; $display("FAIL rstmid_result: got %b %h expected 1 4444444444444444", out_valid, out_sh0 ^ out_sh1); end
        drive(1'b0, '0, '0, '0, 1'b1, acc, ov, o0, o1);
    endtask

    // Flipping one share of one variable may only disturb components that read that share.
    task automatic test_noncompleteness();
        logic acc, ov;
        logic [DW-1:0] o0, o1, s0, s1, f;
        logic [RW-1:0] r;
        logic [CW-1:0] base, snap, mask;
        s0 = rand_dw(); s1 = rand_dw(); r = rand_vec();
        drive(1'b1, s0, s1, r, 1'b1, acc, ov, o0, o1);
        base = dut.comp_q;
        drive(1'b0, '0, '0, '0, 1'b1, acc, ov, o0, o1);
        drive(1'b0, '0, '0, '0, 1'b1, acc, ov, o0, o1);
        for (int sel = 0; sel < 2; sel++) begin
            for (int v = 0; v < 4; v++) begin
                f = {NIB{4'(1 << v)}};
                drive(1'b1, (sel == 0) ? (s0 ^ f) : s0, (sel == 1) ? (s1 ^ f) : s1, r, 1'b1, acc, ov, o0, o1);
                snap = dut.comp_q;
                for (int i = 0; i < int'(CW); i++) mask[i] = (((i % 16) >> v) & 1) != sel;
                n_checks++; if (((snap ^ base) & mask) !== '0) begin
                    n_fail++; $display("FAIL noncomplete_sh%0d_var%0d: got disturbed components %h expected 0", sel, v, (snap ^ base) & mask); end
                n_checks++; if (((snap ^ base) & ~mask) === '0) begin
                    n_fail++; $display("FAIL noncomplete_dep_sh%0d_var%0d: got no change expected dependent components to change", sel, v); end
                drive(1'b0, '0, '0, '0, 1'b1, acc, ov, o0, o1);
                drive(1'b0, '0, '0, '0, 1'b1, acc, ov, o0, o1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exhaustive_stream();
        test_rand_variation();
        test_backpressure();
        test_reset_midstream();
        test_noncompleteness();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
